// File: rtl/usb_in_ep_sched.sv
// usb_in_ep_sched: shares the controller IN tx port between NUM_EP bulk IN
// endpoint FWFT FIFOs (endpoints 1..NUM_EP).
// Ports:
//   clk_i, rst_n_i (async active-low), busreset_i (sync clear)
//   highspeed_i          selects MAX_PKT_HS / MAX_PKT_FS
//   endpt_i, txact_i, txpop_i, txpktfin_i   controller tx request side
//   txdat_o, txval_o, txdat_len_o, txcork_o controller tx response side
//   ep_level_i, ep_data_i, ep_pop_o         per-endpoint FIFO side
//   underrun_o (sticky), abort_o (pulse)    error flags
// Optional: define USB_IN_ZLP_EN to send a zero-length packet after a
// max-size packet that empties its FIFO.
module usb_in_ep_sched #(
  parameter int NUM_EP     = 3,
  parameter int MAX_PKT_HS = 512,
  parameter int MAX_PKT_FS = 64,
  parameter int LEN_W      = 12
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    busreset_i,
  input  logic                    highspeed_i,
  input  logic [3:0]              endpt_i,
  input  logic                    txact_i,
  input  logic                    txpop_i,
  input  logic                    txpktfin_i,
  output logic [7:0]              txdat_o,
  output logic                    txval_o,
  output logic [LEN_W-1:0]        txdat_len_o,
  output logic                    txcork_o,
  input  logic [NUM_EP*LEN_W-1:0] ep_level_i,
  input  logic [NUM_EP*8-1:0]     ep_data_i,
  output logic [NUM_EP-1:0]       ep_pop_o,
  output logic                    underrun_o,
  output logic                    abort_o
);

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [2:0]       sel_ep;
  logic             sel_vld;
  logic [LEN_W-1:0] rem;
  logic [LEN_W-1:0] rem_nxt;
  logic [LEN_W-1:0] len_q;
  logic             cork_q;
  logic             underrun_q;
  logic             abort_q;
  logic             abort_nxt;
  logic             txact_d;
  logic [NUM_EP-1:0] zlp_pending;

  logic             ep_vld;
  logic [2:0]       ep_idx;
  logic [LEN_W-1:0] maxpkt;
  logic [LEN_W-1:0] cur_level;
  logic [LEN_W-1:0] cur_len;
  logic             cur_zlp;
  logic             cur_cork;
  logic [7:0]       sel_data;
  logic             in_send;
  logic             do_pop;
  logic             txact_rise;

  assign maxpkt = highspeed_i ? LEN_W'(MAX_PKT_HS)
                              : LEN_W'(MAX_PKT_FS);

  assign ep_vld = (endpt_i != 4'd0) &&
                  (endpt_i <= 4'(NUM_EP));
  assign ep_idx = endpt_i[2:0] - 3'd1;

  always_comb begin
    cur_level = '0;
    cur_zlp   = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (ep_vld && ep_idx == 3'(i)) begin
        cur_level = ep_level_i[i*LEN_W +: LEN_W];
        cur_zlp   = zlp_pending[i];
      end
      if (sel_vld && sel_ep == 3'(i)) begin
        sel_data = ep_data_i[i*8 +: 8];
      end
    end
  end

  // Saturate only for the length compare; the FIFO level is untouched.
  assign cur_len  = (cur_level > maxpkt) ? maxpkt : cur_level;
  assign cur_cork = ep_vld ? ((cur_level == '0) && !cur_zlp)
                           : 1'b1;

  assign in_send    = (state == SEND);
  assign do_pop     = in_send && txpop_i && (rem != '0);
  assign rem_nxt    = do_pop ? rem - 1'b1 : rem;
  assign txact_rise = txact_i && !txact_d;

  always_comb begin
    state_nxt = state;
    abort_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (txact_rise) state_nxt = SEND;
      end
      SEND: begin
        // pktfin wins over a simultaneous txact fall
        if (txpktfin_i) begin
          state_nxt = DONE;
        end else if (!txact_i) begin
          state_nxt = IDLE;
          abort_nxt = (rem_nxt != '0);
        end
      end
      DONE: begin
        if (!txact_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ep_pop_o = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      ep_pop_o[i] = do_pop && sel_vld &&
                    (sel_ep == 3'(i));
    end
  end

  assign txdat_o     = in_send ? sel_data : 8'h00;
  assign txval_o     = in_send && (rem != '0);
  assign txdat_len_o = len_q;
  assign txcork_o    = cork_q;
  assign underrun_o  = underrun_q;
  assign abort_o     = abort_q;

  // Tracks txact even through bus reset so a rise seen during
  // bus reset is swallowed rather than replayed afterwards.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) txact_d <= 1'b0;
    else          txact_d <= txact_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= IDLE;
      sel_ep     <= '0;
      sel_vld    <= 1'b0;
      rem        <= '0;
      len_q      <= '0;
      cork_q     <= 1'b1;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else if (busreset_i) begin
      state      <= IDLE;
      sel_ep     <= '0;
      sel_vld    <= 1'b0;
      rem        <= '0;
      len_q      <= '0;
      cork_q     <= 1'b1;
      underrun_q <= 1'b0;
      abort_q    <= 1'b0;
    end else begin
      state   <= state_nxt;
      abort_q <= abort_nxt;
      if (in_send) rem <= rem_nxt;
      if (in_send && txpop_i && rem == '0)
        underrun_q <= 1'b1;
      if (state == IDLE) begin
        len_q  <= cur_len;
        cork_q <= cur_cork;
        if (txact_rise) begin
          sel_ep  <= ep_idx;
          sel_vld <= ep_vld;
          rem     <= cur_len;
        end
      end
    end
  end

`ifdef USB_IN_ZLP_EN
  logic [LEN_W-1:0] lock_len;
  logic [LEN_W-1:0] sel_level;
  logic             zlp_set;

  always_comb begin
    sel_level = '0;
    for (int i = 0; i < NUM_EP; i++) begin
      if (sel_vld && sel_ep == 3'(i))
        sel_level = ep_level_i[i*LEN_W +: LEN_W];
    end
  end

  // A full packet that drained the FIFO needs a ZLP terminator;
  // any other completed packet (including the ZLP) clears it.
  assign zlp_set = (lock_len == maxpkt) &&
                   (sel_level == '0);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lock_len    <= '0;
      zlp_pending <= '0;
    end else if (busreset_i) begin
      lock_len    <= '0;
      zlp_pending <= '0;
    end else begin
      if (state == IDLE && txact_rise)
        lock_len <= cur_len;
      if (state == DONE && sel_vld) begin
        for (int i = 0; i < NUM_EP; i++) begin
          if (sel_ep == 3'(i))
            zlp_pending[i] <= zlp_set;
        end
      end
    end
  end
`else
  assign zlp_pending = '0;
`endif

endmodule

// File: tb/tb_usb_in_ep_sched.sv
// tb_usb_in_ep_sched: self-checking bench for usb_in_ep_sched.
// FIFOs are modelled as byte queues; expectations come from queue sizes.
module tb_usb_in_ep_sched;
  localparam int NUM_EP = 3;
  localparam int LEN_W  = 12;
  localparam int HS     = 512;
  localparam int FS     = 64;
`ifdef USB_IN_ZLP_EN
  localparam bit ZLP = 1'b1;
`else
  localparam bit ZLP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busreset = 1'b0;
  logic hs = 1'b0;
  logic [3:0] endpt = 4'd0;
  logic txact = 1'b0;
  logic txpop = 1'b0;
  logic txpktfin = 1'b0;
  logic [7:0] txdat;
  logic txval;
  logic [LEN_W-1:0] txlen;
  logic txcork;
  logic [NUM_EP*LEN_W-1:0] ep_level;
  logic [NUM_EP*8-1:0] ep_data;
  logic [NUM_EP-1:0] ep_pop;
  logic underrun;
  logic abort_p;

  int n_cmp = 0;
  int n_err = 0;

  byte unsigned q[NUM_EP][$];
  byte unsigned snap[$];
  byte unsigned obs_q[$];
  bit zlp_m[NUM_EP];
  logic [NUM_EP-1:0] pend;

  int obs_pops, obs_stray, obs_lenchg, obs_val;
  logic [LEN_W-1:0] obs_len;
  logic obs_cork, obs_ab_pre, obs_ab1, obs_ab2;

  usb_in_ep_sched #(
    .NUM_EP(NUM_EP), .MAX_PKT_HS(HS),
    .MAX_PKT_FS(FS), .LEN_W(LEN_W)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .busreset_i(busreset), .highspeed_i(hs),
    .endpt_i(endpt), .txact_i(txact),
    .txpop_i(txpop), .txpktfin_i(txpktfin),
    .txdat_o(txdat), .txval_o(txval),
    .txdat_len_o(txlen), .txcork_o(txcork),
    .ep_level_i(ep_level), .ep_data_i(ep_data),
    .ep_pop_o(ep_pop), .underrun_o(underrun),
    .abort_o(abort_p)
  );

  always #8 clk = ~clk;

  // FIFO model: pops sampled mid-cycle, applied at the edge.
  always @(negedge clk) pend = ep_pop;

  always @(posedge clk) begin
    for (int i = 0; i < NUM_EP; i++) begin
      if (pend[i] && q[i].size() > 0)
        void'(q[i].pop_front());
      ep_level[i*LEN_W +: LEN_W] <= LEN_W'(q[i].size());
      ep_data[i*8 +: 8] <=
        (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int e, input int n);
    for (int k = 0; k < n; k++)
      q[e-1].push_back(8'($urandom));
  endtask

  task automatic flush();
    for (int i = 0; i < NUM_EP; i++) q[i].delete();
    tick();
    tick();
  endtask

  task automatic zlp_clear();
    for (int i = 0; i < NUM_EP; i++) zlp_m[i] = 1'b0;
  endtask

  function automatic int exp_len(input int e);
    int lv, mp;
    if (e < 1 || e > NUM_EP) return 0;
    lv = q[e-1].size();
    mp = hs ? HS : FS;
    return (lv < mp) ? lv : mp;
  endfunction

  function automatic bit exp_cork(input int e);
    if (e < 1 || e > NUM_EP) return 1'b1;
    return (q[e-1].size() == 0) && !zlp_m[e-1];
  endfunction

  // Completed packet of length l on endpoint e.
  function automatic void model_done(input int e, input int l);
    int mp;
    mp = hs ? HS : FS;
    if (ZLP && e >= 1 && e <= NUM_EP)
      zlp_m[e-1] = (l == mp) && (q[e-1].size() == 0);
  endfunction

  function automatic int data_bad();
    int b;
    b = 0;
    for (int k = 0; k < obs_q.size(); k++)
      if (k >= snap.size() || obs_q[k] != snap[k]) b++;
    return b;
  endfunction

  // Controller-side driver: records observations only.
  task automatic drive_in(input int e, input int npops,
                          input bit fin);
    logic [NUM_EP-1:0] tmask;
    tmask = '0;
    if (e >= 1 && e <= NUM_EP) tmask[e-1] = 1'b1;
    obs_q.delete();
    obs_pops = 0; obs_stray = 0;
    obs_lenchg = 0; obs_val = 0;
    obs_ab_pre = 0; obs_ab1 = 0; obs_ab2 = 0;
    endpt = 4'(e);
    tick();
    tick();
    obs_len = txlen;
    obs_cork = txcork;
    txact = 1'b1;
    tick();
    for (int k = 0; k < npops; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      txpop = 1'b1;
      @(negedge clk);
      if ((ep_pop & tmask) != 0) begin
        obs_pops++;
        obs_q.push_back(txdat);
      end
      if ((ep_pop & ~tmask) != 0) obs_stray++;
      if (txval) obs_val++;
      if (txlen !== obs_len) obs_lenchg++;
      @(posedge clk);
      #1;
      txpop = 1'b0;
    end
    if (fin) begin
      txpktfin = 1'b1;
      tick();
      txpktfin = 1'b0;
      txact = 1'b0;
      tick();
      tick();
      tick();
    end else begin
      txact = 1'b0;
      @(negedge clk);
      obs_ab_pre = abort_p;
      @(negedge clk);
      obs_ab1 = abort_p;
      @(negedge clk);
      obs_ab2 = abort_p;
      tick();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (txcork !== 1'b1) begin n_err++;
      $display("FAIL rst_cork: got %b want 1", txcork); end
    n_cmp++; if (txlen !== '0) begin n_err++;
      $display("FAIL rst_len: got %0d want 0", txlen); end
    n_cmp++; if (txval !== 1'b0) begin n_err++;
      $display("FAIL rst_val: got %b want 0", txval); end
    n_cmp++; if (ep_pop !== '0) begin n_err++;
      $display("FAIL rst_pop: got %b want 0", ep_pop); end
    n_cmp++; if (underrun !== 1'b0) begin n_err++;
      $display("FAIL rst_underrun: got %b want 0", underrun); end
    n_cmp++; if (abort_p !== 1'b0) begin n_err++;
      $display("FAIL rst_abort: got %b want 0", abort_p); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_len_cork();
    endpt = 4'd1;
    tick();
    tick();
    n_cmp++; if (txcork !== 1'b1) begin n_err++;
      $display("FAIL empty_cork: got %b want 1", txcork); end
    n_cmp++; if (txlen !== '0) begin n_err++;
      $display("FAIL empty_len: got %0d want 0", txlen); end
    push(1, 10);
    tick();
    tick();
    n_cmp++; if (txcork !== exp_cork(1)) begin n_err++;
      $display("FAIL lvl_cork: got %b want %b",
               txcork, exp_cork(1)); end
    n_cmp++; if (txlen !== LEN_W'(exp_len(1))) begin n_err++;
      $display("FAIL lvl_len: got %0d want %0d",
               txlen, exp_len(1)); end
  endtask

  task automatic test_fs_split();
    int l;
    hs = 1'b0;
    flush();
    push(2, 100);
    l = exp_len(2);
    snap = q[1];
    drive_in(2, 64, 1'b1);
    n_cmp++; if (obs_len !== LEN_W'(l)) begin n_err++;
      $display("FAIL fs_len: got %0d want %0d", obs_len, l); end
    n_cmp++; if (obs_pops != l) begin n_err++;
      $display("FAIL fs_pops: got %0d want %0d", obs_pops, l); end
    n_cmp++; if (obs_stray != 0) begin n_err++;
      $display("FAIL fs_stray: got %0d want 0", obs_stray); end
    n_cmp++; if (data_bad() != 0) begin n_err++;
      $display("FAIL fs_data: got %0d bad want 0", data_bad()); end
    n_cmp++; if (obs_lenchg != 0) begin n_err++;
      $display("FAIL fs_frozen: got %0d want 0", obs_lenchg); end
    n_cmp++; if (obs_val != l) begin n_err++;
      $display("FAIL fs_val: got %0d want %0d", obs_val, l); end
    model_done(2, l);
    n_cmp++; if (txlen !== LEN_W'(exp_len(2))) begin n_err++;
      $display("FAIL fs_next_len: got %0d want %0d",
               txlen, exp_len(2)); end
  endtask

  task automatic test_zlp();
    int l;
    hs = 1'b1;
    flush();
    push(1, 512);
    l = exp_len(1);
    drive_in(1, l, 1'b1);
    n_cmp++; if (obs_pops != l) begin n_err++;
      $display("FAIL hs_pops: got %0d want %0d", obs_pops, l); end
    model_done(1, l);
    n_cmp++; if (txcork !== exp_cork(1)) begin n_err++;
      $display("FAIL zlp_cork: got %b want %b",
               txcork, exp_cork(1)); end
    n_cmp++; if (txlen !== '0) begin n_err++;
      $display("FAIL zlp_len: got %0d want 0", txlen); end
    drive_in(1, 0, 1'b1);
    model_done(1, 0);
    n_cmp++; if (txcork !== exp_cork(1)) begin n_err++;
      $display("FAIL zlp_after_cork: got %b want %b",
               txcork, exp_cork(1)); end
  endtask

  task automatic test_underrun();
    flush();
    push(3, 5);
    drive_in(3, 6, 1'b1);
    n_cmp++; if (obs_pops != 5) begin n_err++;
      $display("FAIL ur_pops: got %0d want 5", obs_pops); end
    n_cmp++; if (obs_val != 5) begin n_err++;
      $display("FAIL ur_val: got %0d want 5", obs_val); end
    model_done(3, 5);
    repeat (5) tick();
    n_cmp++; if (underrun !== 1'b1) begin n_err++;
      $display("FAIL ur_sticky: got %b want 1", underrun); end
    busreset = 1'b1;
    tick();
    busreset = 1'b0;
    zlp_clear();
    n_cmp++; if (underrun !== 1'b0) begin n_err++;
      $display("FAIL ur_clear: got %b want 0", underrun); end
  endtask

  task automatic test_abort();
    hs = 1'($urandom_range(0, 1));
    flush();
    push(1, 8);
    snap = q[0];
    drive_in(1, 3, 1'b0);
    n_cmp++; if (obs_pops != 3) begin n_err++;
      $display("FAIL ab_pops: got %0d want 3", obs_pops); end
    n_cmp++; if (data_bad() != 0) begin n_err++;
      $display("FAIL ab_data: got %0d bad want 0", data_bad()); end
    n_cmp++; if ({obs_ab_pre, obs_ab1, obs_ab2} !== 3'b010)
      begin n_err++;
      $display("FAIL ab_pulse: got %b want 010",
               {obs_ab_pre, obs_ab1, obs_ab2}); end
    n_cmp++; if (txval !== 1'b0) begin n_err++;
      $display("FAIL ab_idle_val: got %b want 0", txval); end
    n_cmp++; if (txlen !== LEN_W'(exp_len(1))) begin n_err++;
      $display("FAIL ab_len: got %0d want %0d",
               txlen, exp_len(1)); end
  endtask

  task automatic test_invalid();
    int eps[2];
    eps[0] = 0;
    eps[1] = NUM_EP + 1;
    flush();
    for (int i = 1; i <= NUM_EP; i++) push(i, 100);
    foreach (eps[j]) begin
      drive_in(eps[j], 4, 1'b1);
      n_cmp++; if (obs_cork !== 1'b1) begin n_err++;
        $display("FAIL inv_cork ep%0d: got %b want 1",
                 eps[j], obs_cork); end
      n_cmp++; if (obs_len !== '0) begin n_err++;
        $display("FAIL inv_len ep%0d: got %0d want 0",
                 eps[j], obs_len); end
      n_cmp++; if (obs_stray != 0) begin n_err++;
        $display("FAIL inv_pop ep%0d: got %0d want 0",
                 eps[j], obs_stray); end
    end
    busreset = 1'b1;
    tick();
    busreset = 1'b0;
    zlp_clear();
  endtask

  task automatic test_midsend_reset();
    flush();
    push(2, 20);
    endpt = 4'd2;
    tick();
    tick();
    txact = 1'b1;
    tick();
    txpop = 1'b1;
    tick();
    tick();
    n_cmp++; if (txval !== 1'b1) begin n_err++;
      $display("FAIL ms_pre_val: got %b want 1", txval); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (txval !== 1'b0) begin n_err++;
      $display("FAIL ms_val: got %b want 0", txval); end
    n_cmp++; if (ep_pop !== '0) begin n_err++;
      $display("FAIL ms_pop: got %b want 0", ep_pop); end
    n_cmp++; if (txcork !== 1'b1 || txlen !== '0) begin n_err++;
      $display("FAIL ms_cork_len: got %b/%0d want 1/0",
               txcork, txlen); end
    txpop = 1'b0;
    txact = 1'b0;
    tick();
    rst_n = 1'b1;
    zlp_clear();
    tick();
    tick();
    tick();
    n_cmp++; if (txlen !== LEN_W'(exp_len(2))) begin n_err++;
      $display("FAIL ms_after_len: got %0d want %0d",
               txlen, exp_len(2)); end
  endtask

  task automatic test_random();
    int e, l;
    bit c;
    for (int it = 0; it < 20; it++) begin
      e = $urandom_range(1, NUM_EP);
      hs = 1'($urandom_range(0, 1));
      if (q[e-1].size() < 900) push(e, $urandom_range(0, 130));
      tick();
      tick();
      l = exp_len(e);
      c = exp_cork(e);
      snap = q[e-1];
      drive_in(e, l, 1'b1);
      n_cmp++; if (obs_len !== LEN_W'(l) || obs_cork !== c)
        begin n_err++;
        $display("FAIL rnd_len_cork it%0d: got %0d/%b want %0d/%b",
                 it, obs_len, obs_cork, l, c); end
      n_cmp++; if (obs_pops != l || obs_stray != 0) begin n_err++;
        $display("FAIL rnd_pops it%0d: got %0d/%0d want %0d/0",
                 it, obs_pops, obs_stray, l); end
      n_cmp++; if (data_bad() != 0) begin n_err++;
        $display("FAIL rnd_data it%0d: got %0d bad want 0",
                 it, data_bad()); end
      model_done(e, l);
    end
  endtask

  initial begin
    zlp_clear();
    test_reset();
    test_len_cork();
    test_fs_split();
    test_zlp();
    test_underrun();
    test_abort();
    test_invalid();
    test_midsend_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
